// File: rtl/match_event_logger_pkg.sv
// Shared widths and helpers for the match event logger.
// Default parameter values and FIFO pointer sizing.
package match_event_logger_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/match_event_logger_evt_fifo.sv
// evt_fifo: generic sync first-word-fall-through FIFO with flush.
// Ports: push/data in, pop, rdata (head), full, empty.
module evt_fifo
  import match_event_logger_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);

  // a pop frees the slot, so a full FIFO may accept in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps rising edges of match_i into an event FIFO for a reader.
// Ports: match_i/clr_i in; evt valid/ready/ts; match count; overflow.
module match_event_logger
  import match_event_logger_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_i,
  input  logic             clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [TS_W-1:0]  evt_ts_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts_q, hold_q, head;
  logic [CNT_W-1:0] cnt_q;
  logic             match_q, ovf_q;
  logic             evt, push, pop, full, empty;

  assign evt  = match_i && !match_q;
  assign push = evt && !clr_i;
  assign pop  = evt_valid_o && evt_ready_i && !clr_i;

  evt_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr_i),
    .push  (push),
    .data  (ts_q),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid_o = !empty;
  // keep showing the last head once the queue runs dry
  assign evt_ts_o    = empty ? hold_q : head;
  assign match_cnt_o = cnt_q;
  assign overflow_o  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      match_q <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      match_q <= match_i;
      if (!empty) hold_q <= head;
      if (clr_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (evt && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (evt && full && !pop)     ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Downstream consumer of the 2-bit-symbol sequence detector's 1-bit match output (`ans`, high for one cycle per detected sequence).
- Turns each match into a timestamped event and queues it in a small FIFO.
- Presents events to a reader over a valid/ready handshake.
- Keeps a saturating match count and a sticky overflow flag for status readout.

Parameters:
- TS_W, 16, width of the free-running cycle timestamp.
- DEPTH, 4, event FIFO entries; must be a power of two and ≥2.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- match_i  in  1  match level from the sequence detector.
- clr_i  in  1  synchronous clear: flush FIFO, zero count, clear overflow.
- evt_valid_o  out  1  FIFO head holds a valid event.
- evt_ready_i  in  1  reader accepts the head event this cycle.
- evt_ts_o  out  TS_W  timestamp of the head event.
- match_cnt_o  out  CNT_W  total detected matches, saturating.
- overflow_o  out  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (rst_n low, async):
  - ts_q=0, match_q=0, FIFO empty.
  - evt_valid_o=0, evt_ts_o=0, match_cnt_o=0, overflow_o=0.
- Timestamp:
  - ts_q increments by 1 every clk.
  - Wraps from 2^TS_W-1 to 0.
  - Unaffected by clr_i.
- Edge detect:
  - match_q <= match_i each cycle.
  - An event occurs when match_i=1 && match_q=0.
  - A level held high for N cycles is one event.
  - match_i already high in the first cycle after reset counts, because match_q resets to 0.
- Capture:
  - On an event cycle, the ts_q value of that cycle is pushed at that clock edge.
  - The event is visible at the FIFO head on the next cycle (latency 1).
  - No combinational path from match_i to evt_valid_o.
- FIFO:
  - First-word-fall-through. evt_ts_o shows the head whenever evt_valid_o=1.
  - evt_ts_o holds its last value when empty; it is 0 after reset.
  - Pop when evt_valid_o && evt_ready_i.
  - Read/write pointers are log2(DEPTH)+1 bits. Empty when pointers are equal; full when the MSBs differ and the rest match.
- Boundaries:
  - Push while full with no pop: event dropped, FIFO unchanged, overflow_o <= 1.
  - Push while full with a pop in the same cycle: both take effect, no drop, count stays DEPTH.
  - Push while empty: no pop possible that cycle (evt_valid_o=0); count becomes 1.
  - Pointers wrap modulo 2·DEPTH.
- Counter:
  - match_cnt_o increments on every event, including dropped ones.
  - Holds at 2^CNT_W-1.
- clr_i (synchronous):
  - Next cycle: FIFO empty, match_cnt_o=0, overflow_o=0.
  - clr_i beats any push, pop or count in the same cycle; an event in that cycle is lost and not counted.
  - match_q still updates.
- Reset mid-operation: all state is lost immediately and asynchronously. Deassertion is assumed synchronous to clk upstream.
- Handshake rules on the reader side:
  - evt_valid_o never drops without a pop or clr_i.
  - evt_ts_o is stable while evt_valid_o=1 && evt_ready_i=0.

Decomposition:
- Shared package: default widths (TS_W, DEPTH, CNT_W) and a count-width helper constant, log2(DEPTH)+1.
- One sub-module: evt_fifo.
  - Generic sync FWFT FIFO with flush input.
  - Ports: push/data/pop/full/empty.
  - Reused later for other event queues.
- Edge detect, timestamp and counter stay in the top level.

Test Plan:
- Reset, then single-cycle match_i pulse at ts_q=5 with evt_ready_i=0 → next cycle evt_valid_o=1, evt_ts_o=5, match_cnt_o=1; raise evt_ready_i → evt_valid_o=0 one cycle later.
- match_i held high for 6 cycles starting at ts_q=10 → exactly one event (ts=10), match_cnt_o=1.
- evt_ready_i=0, 5 pulses at ts 20,22,24,26,28 with DEPTH=4 → FIFO holds 20,22,24,26; overflow_o=1 after the 28 push; match_cnt_o=5; draining yields 20,22,24,26 in order.
- FIFO full with evt_ready_i=1 and a pulse in the same cycle → head pops and the new event is appended, overflow_o stays 0, evt_valid_o stays 1.
- CNT_W=8, 300 pulses, FIFO continuously drained → match_cnt_o saturates at 255; TS_W=4 run past 15 → captured timestamp wraps to 0.
- clr_i asserted in the same cycle as a match edge with 2 queued events → next cycle evt_valid_o=0, match_cnt_o=0, overflow_o=0, no event queued; async rst_n pulse mid-drain → outputs 0 immediately.
